// File: rtl/apb_cmd_master.sv
// APB3 requester: converts single-beat local commands into APB transfers
// and returns read data and error/timeout status on a response channel.
module apb_cmd_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   // A zero TIMEOUT still needs a 1-bit counter to keep the declarations legal.
   localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_t;

   state_t            state, state_next;
   logic [CNT_W-1:0]  stall_cnt, cnt_inc;
   logic              timeout_hit;
   logic              pwrite_q;
   logic [ADDR_W-1:0] paddr_q;
   logic [DATA_W-1:0] pwdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q, tmo_q;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next  = state;
      cmd_ready   = 1'b0;
      PSEL        = 1'b0;
      PENABLE     = 1'b0;
      rsp_valid   = 1'b0;
      cnt_inc     = (stall_cnt == '1) ? stall_cnt : stall_cnt + 1'b1;
      timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_VAL);
      case (state)
         IDLE: begin
            cmd_ready = PRESETn;
            if (cmd_valid) state_next = SETUP;
         end
         SETUP: begin
            PSEL       = 1'b1;
            state_next = ACCESS;
         end
         ACCESS: begin
            PSEL    = 1'b1;
            PENABLE = 1'b1;
            if (PREADY || timeout_hit) state_next = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Command fields are latched once at accept; read data is zeroed for writes/timeouts.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         stall_cnt <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  pwrite_q  <= cmd_write;
                  paddr_q   <= cmd_addr;
                  pwdata_q  <= cmd_write ? cmd_wdata : '0;
                  stall_cnt <= '0;
               end
            end
            ACCESS: begin
               if (PREADY) begin
                  rdata_q <= pwrite_q ? '0 : PRDATA;
                  err_q   <= PSLVERR;
                  tmo_q   <= 1'b0;
               end else begin
                  stall_cnt <= cnt_inc;
                  if (timeout_hit) begin
                     rdata_q <= '0;
                     err_q   <= 1'b1;
                     tmo_q   <= 1'b1;
                  end
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rdata_q <= '0;
                  err_q   <= 1'b0;
                  tmo_q   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign PWRITE      = pwrite_q;
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign rsp_rdata   = rdata_q;
   assign rsp_err     = err_q;
   assign rsp_timeout = tmo_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed self-checking bench for apb_cmd_master with TIMEOUT=16.
module tb_apb_cmd_master;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err, rsp_timeout;
   logic        PSEL, PENABLE, PWRITE;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic        PREADY, PSLVERR;

   int total = 0;
   int bad   = 0;

   apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents one command in IDLE; returns one cycle later in SETUP.
   task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = data;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      PRESETn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      rsp_ready = 1'b1;
      PRDATA    = '0;
      PREADY    = 1'b0;
      PSLVERR   = 1'b0;

      tick();
      tick();
      chk("rst_psel", PSEL, 0);
      chk("rst_penable", PENABLE, 0);
      chk("rst_pwrite", PWRITE, 0);
      chk("rst_paddr", PADDR, 0);
      chk("rst_pwdata", PWDATA, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      PRESETn = 1'b1;
      tick();
      chk("idle_cmd_ready", cmd_ready, 1);

      // 1: write 0xABC to 0x008, PREADY=1
      PREADY = 1'b1;
      issue(1'b1, 32'h008, 32'h0000_0ABC);
      chk("t1_setup_psel", PSEL, 1);
      chk("t1_setup_penable", PENABLE, 0);
      chk("t1_setup_cmd_ready", cmd_ready, 0);
      tick();
      chk("t1_access_penable", PENABLE, 1);
      chk("t1_access_psel", PSEL, 1);
      chk("t1_paddr", PADDR, 32'h008);
      chk("t1_pwdata", PWDATA, 32'h0000_0ABC);
      chk("t1_pwrite", PWRITE, 1);
      tick();
      chk("t1_rsp_valid", rsp_valid, 1);
      chk("t1_rsp_psel", PSEL, 0);
      chk("t1_rsp_err", rsp_err, 0);
      chk("t1_rsp_rdata", rsp_rdata, 0);
      tick();
      chk("t1_cmd_ready", cmd_ready, 1);
      chk("t1_rsp_dropped", rsp_valid, 0);

      // 2: read 0x004 with three stalled ACCESS cycles
      PREADY = 1'b0;
      PRDATA = 32'h0001_2345;
      issue(1'b0, 32'h004, 32'hFFFF_FFFF);
      chk("t2_pwdata_read", PWDATA, 0);
      chk("t2_pwrite", PWRITE, 0);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t2_access%0d_penable", i), PENABLE, 1);
         chk($sformatf("t2_access%0d_paddr", i), PADDR, 32'h004);
         if (i == 3) PREADY = 1'b1;
         tick();
      end
      chk("t2_rsp_valid", rsp_valid, 1);
      chk("t2_rsp_rdata", rsp_rdata, 32'h0001_2345);
      chk("t2_rsp_err", rsp_err, 0);
      tick();

      // 3: read 0x000 with PSLVERR
      PSLVERR = 1'b1;
      PRDATA  = 32'hDEAD_0001;
      issue(1'b0, 32'h000, 32'h0);
      tick();
      tick();
      chk("t3_rsp_valid", rsp_valid, 1);
      chk("t3_rsp_err", rsp_err, 1);
      chk("t3_rsp_timeout", rsp_timeout, 0);
      chk("t3_rsp_rdata", rsp_rdata, 32'hDEAD_0001);
      tick();
      PSLVERR = 1'b0;

      // 4: PREADY held low -> timeout after 16 ACCESS cycles
      PREADY = 1'b0;
      PRDATA = 32'hCAFE_F00D;
      issue(1'b0, 32'h040, 32'h0);
      tick();
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("t4_stall%0d_psel", i), PSEL, 1);
         tick();
      end
      chk("t4_psel_dropped", PSEL, 0);
      chk("t4_rsp_valid", rsp_valid, 1);
      chk("t4_rsp_err", rsp_err, 1);
      chk("t4_rsp_timeout", rsp_timeout, 1);
      chk("t4_rsp_rdata", rsp_rdata, 0);
      tick();
      PREADY = 1'b1;
      issue(1'b1, 32'h010, 32'h1234_5678);
      tick();
      tick();
      chk("t4_next_rsp_valid", rsp_valid, 1);
      chk("t4_next_err", rsp_err, 0);
      chk("t4_next_timeout", rsp_timeout, 0);
      tick();

      // 5: response backpressure with a pending command
      PRDATA = 32'h0000_55AA;
      rsp_ready = 1'b0;
      issue(1'b0, 32'h020, 32'h0);
      tick();
      tick();
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h024;
      cmd_wdata = 32'h0000_0077;
      PRDATA    = 32'h0BAD_0BAD;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t5_hold%0d_rsp_valid", i), rsp_valid, 1);
         chk($sformatf("t5_hold%0d_rdata", i), rsp_rdata, 32'h0000_55AA);
         chk($sformatf("t5_hold%0d_cmd_ready", i), cmd_ready, 0);
         chk($sformatf("t5_hold%0d_psel", i), PSEL, 0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      chk("t5_idle_cmd_ready", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      chk("t5_setup_psel", PSEL, 1);
      chk("t5_setup_penable", PENABLE, 0);
      chk("t5_setup_paddr", PADDR, 32'h024);
      chk("t5_setup_pwdata", PWDATA, 32'h0000_0077);
      tick();
      tick();
      chk("t5_rsp2_valid", rsp_valid, 1);
      chk("t5_rsp2_rdata", rsp_rdata, 0);
      tick();

      // 6: reset asserted during ACCESS
      PREADY = 1'b0;
      issue(1'b0, 32'h030, 32'h0);
      tick();
      chk("t6_access_penable", PENABLE, 1);
      PRESETn = 1'b0;
      #1;
      chk("t6_rst_psel", PSEL, 0);
      chk("t6_rst_penable", PENABLE, 0);
      chk("t6_rst_rsp_valid", rsp_valid, 0);
      chk("t6_rst_cmd_ready", cmd_ready, 0);
      PREADY = 1'b1;
      tick();
      PRESETn = 1'b1;
      tick();
      chk("t6_post_cmd_ready", cmd_ready, 1);
      chk("t6_post_rsp_valid", rsp_valid, 0);
      tick();
      chk("t6_post2_rsp_valid", rsp_valid, 0);
      chk("t6_post2_psel", PSEL, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
